// File: rtl/desplazamiento_izquierda_secuencial.sv
// Multi-cycle logical left shifter: captures an operand and a 0..7 shift amount,
// shifts one bit per clock and publishes the result and last carry-out with a done pulse.
module desplazamiento_izquierda_secuencial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic [7:0] valor_in,
  input  logic [2:0] cant_mov,
  output logic [7:0] valor_desplazado,
  output logic       acarreo,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    DESPLAZANDO = 2'd1,
    FIN         = 2'd2
  } estado_t;

  estado_t    estado;
  logic [7:0] reg_d;
  logic [2:0] cnt;
  logic       c_int;

  // ocupado/listo are registered alongside the state so they mirror it exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado           <= REPOSO;
      reg_d            <= 8'h00;
      cnt              <= 3'd0;
      c_int            <= 1'b0;
      valor_desplazado <= 8'h00;
      acarreo          <= 1'b0;
      ocupado          <= 1'b0;
      listo            <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            reg_d   <= valor_in;
            cnt     <= cant_mov;
            c_int   <= 1'b0;
            ocupado <= 1'b1;
            if (cant_mov == 3'd0) begin
              estado           <= FIN;
              listo            <= 1'b1;
              valor_desplazado <= valor_in;
              acarreo          <= 1'b0;
            end else begin
              estado <= DESPLAZANDO;
              listo  <= 1'b0;
            end
          end
        end
        DESPLAZANDO: begin
          reg_d <= {reg_d[6:0], 1'b0};
          c_int <= reg_d[7];
          cnt   <= cnt - 3'd1;
          // The last shift publishes its own outcome so it is valid during FIN
          if (cnt == 3'd1) begin
            estado           <= FIN;
            listo            <= 1'b1;
            valor_desplazado <= {reg_d[6:0], 1'b0};
            acarreo          <= reg_d[7];
          end
        end
        FIN: begin
          estado  <= REPOSO;
          ocupado <= 1'b0;
          listo   <= 1'b0;
        end
        default: begin
          estado  <= REPOSO;
          ocupado <= 1'b0;
          listo   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desplazamiento_izquierda_secuencial.sv
// Bench for the sequential left shifter: directed and random operations checked
// against an arithmetic model of shift result, carry and handshake timing.
module tb_desplazamiento_izquierda_secuencial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inicio;
  logic [7:0] valor_in;
  logic [2:0] cant_mov;
  logic [7:0] valor_desplazado;
  logic       acarreo;
  logic       ocupado;
  logic       listo;

  int passed = 0;
  int total  = 0;

  logic [7:0] hold_v = 8'h00;
  logic       hold_c = 1'b0;

  desplazamiento_izquierda_secuencial dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inicio           (inicio),
    .valor_in         (valor_in),
    .cant_mov         (cant_mov),
    .valor_desplazado (valor_desplazado),
    .acarreo          (acarreo),
    .ocupado          (ocupado),
    .listo            (listo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_val(input logic [7:0] v, input int n);
    return 8'((int'(v) << n) % 256);
  endfunction

  function automatic logic model_carry(input logic [7:0] v, input int n);
    if (n == 0) return 1'b0;
    return 1'((int'(v) >> (8 - n)) & 1);
  endfunction

  // Called in a REPOSO cycle; returns in the REPOSO cycle right after FIN
  task automatic do_op(input logic [7:0] v, input logic [2:0] n, input bit noise, input bit keep);
    int nn;
    logic [7:0] ev;
    logic ec;
    nn = int'(n);
    ev = model_val(v, nn);
    ec = model_carry(v, nn);
    total++;
    if (ocupado !== 1'b0) $display("FAIL op_idle_before v=%h n=%0d: ocupado got %b expected 0", v, nn, ocupado);
    else passed++;
    valor_in = v; cant_mov = n; inicio = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= nn + 1; k++) begin
      total++;
      if (ocupado !== 1'b1) $display("FAIL op_ocupado v=%h n=%0d k=%0d: got %b expected 1", v, nn, k, ocupado);
      else passed++;
      total++;
      if (listo !== (k == nn + 1)) $display("FAIL op_listo v=%h n=%0d k=%0d: got %b expected %b", v, nn, k, listo, (k == nn + 1));
      else passed++;
      if (k == nn + 1) begin
        total++;
        if (valor_desplazado !== ev) $display("FAIL op_result v=%h n=%0d: got %h expected %h", v, nn, valor_desplazado, ev);
        else passed++;
        total++;
        if (acarreo !== ec) $display("FAIL op_carry v=%h n=%0d: got %b expected %b", v, nn, acarreo, ec);
        else passed++;
      end else begin
        total++;
        if (valor_desplazado !== hold_v || acarreo !== hold_c)
          $display("FAIL op_midhold v=%h n=%0d k=%0d: got %h/%b expected %h/%b", v, nn, k, valor_desplazado, acarreo, hold_v, hold_c);
        else passed++;
      end
      valor_in = 8'($urandom);
      cant_mov = 3'($urandom);
      if (noise) inicio = 1'($urandom_range(0, 1));
      else inicio = keep;
      @(posedge clk); #1;
    end
    total++;
    if (ocupado !== 1'b0 || listo !== 1'b0) $display("FAIL op_done_idle v=%h n=%0d: got ocupado=%b listo=%b expected 0/0", v, nn, ocupado, listo);
    else passed++;
    total++;
    if (valor_desplazado !== ev || acarreo !== ec) $display("FAIL op_done_hold v=%h n=%0d: got %h/%b expected %h/%b", v, nn, valor_desplazado, acarreo, ev, ec);
    else passed++;
    inicio = keep;
    hold_v = ev;
    hold_c = ec;
    $display("op v=%h n=%0d -> %h carry=%b", v, nn, ev, ec);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inicio = 1'b1; valor_in = 8'hFF; cant_mov = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (valor_desplazado !== 8'h00 || acarreo !== 1'b0 || ocupado !== 1'b0 || listo !== 1'b0)
      $display("FAIL reset_state: got %h/%b/%b/%b expected 00/0/0/0", valor_desplazado, acarreo, ocupado, listo);
    else passed++;
    rst_n = 1'b1; inicio = 1'b0;
    hold_v = 8'h00; hold_c = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_directed;
    do_op(8'h3C, 3'd0, 1'b0, 1'b0);
    do_op(8'h83, 3'd7, 1'b0, 1'b0);
    do_op(8'hB5, 3'd3, 1'b0, 1'b0);
  endtask

  task automatic test_hold;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (valor_desplazado !== 8'hA8 || acarreo !== 1'b1 || listo !== 1'b0 || ocupado !== 1'b0)
        $display("FAIL hold cyc=%0d: got %h/%b listo=%b ocupado=%b expected a8/1 0 0", i, valor_desplazado, acarreo, listo, ocupado);
      else passed++;
    end
    $display("hold 10 cycles checked");
  endtask

  task automatic test_ignore;
    valor_in = 8'hFF; cant_mov = 3'd4; inicio = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (ocupado !== 1'b1 || listo !== (k == 5))
        $display("FAIL ignore_hs k=%0d: got ocupado=%b listo=%b expected 1/%b", k, ocupado, listo, (k == 5));
      else passed++;
      valor_in = 8'h01; cant_mov = 3'd1;
      inicio = (k == 2 || k == 5);
      @(posedge clk); #1;
    end
    total++;
    if (valor_desplazado !== 8'hF0 || acarreo !== 1'b1 || ocupado !== 1'b0)
      $display("FAIL ignore_result: got %h/%b ocupado=%b expected f0/1 0", valor_desplazado, acarreo, ocupado);
    else passed++;
    inicio = 1'b0;
    hold_v = 8'hF0; hold_c = 1'b1;
    $display("ignore test FF/4 done");
    do_op(8'h01, 3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    valor_in = 8'h55; cant_mov = 3'd5; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (valor_desplazado !== 8'h00 || acarreo !== 1'b0 || ocupado !== 1'b0 || listo !== 1'b0)
      $display("FAIL midreset_state: got %h/%b/%b/%b expected 00/0/0/0", valor_desplazado, acarreo, ocupado, listo);
    else passed++;
    hold_v = 8'h00; hold_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (listo !== 1'b0 || ocupado !== 1'b0) $display("FAIL midreset_nolisto cyc=%0d: got listo=%b ocupado=%b expected 0/0", i, listo, ocupado);
      else passed++;
    end
    $display("mid-operation reset checked");
    do_op(8'h55, 3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    logic [2:0] n;
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      n = 3'($urandom);
      do_op(v, n, 1'b0, 1'b1);
    end
    inicio = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [7:0] v;
    logic [2:0] n;
    int idle;
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      n = 3'($urandom);
      do_op(v, n, 1'($urandom_range(0, 1)), 1'b0);
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        @(posedge clk); #1;
        total++;
        if (valor_desplazado !== hold_v || acarreo !== hold_c || listo !== 1'b0 || ocupado !== 1'b0)
          $display("FAIL random_idle i=%0d: got %h/%b/%b/%b expected %h/%b/0/0", i, valor_desplazado, acarreo, listo, ocupado, hold_v, hold_c);
        else passed++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; inicio = 1'b0; valor_in = 8'h00; cant_mov = 3'd0;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_hold;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/desplazamiento_izquierda_secuencial.md
# desplazamiento_izquierda_secuencial

Sequential logical left shifter for the 8-bit ALU datapath. It is the counterpart to the combinational right shifter. It accepts an 8-bit operand and a 3-bit shift amount on a start pulse and shifts one bit per clock. It then presents the result, the last bit shifted out, and a one-cycle completion pulse. The ALU control sequencer uses it for multi-cycle left-shift operations, with a start/busy/done handshake.

## Interface
- No parameters; the datapath is fixed at 8 bits and the shift amount at 3 bits.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- inicio  input  1  start request; sampled only in REPOSO.
- valor_in  input  8  operand; captured on an accepted inicio.
- cant_mov  input  3  shift amount 0..7; captured on an accepted inicio.
- valor_desplazado  output  8  registered result; updated only on completion.
- acarreo  output  1  registered last bit shifted out of bit 7; updated only on completion.
- ocupado  output  1  high whenever the state is not REPOSO.
- listo  output  1  one-cycle completion pulse.

## Operation
- States: REPOSO, DESPLAZANDO, FIN. Internal registers: shift register reg_d[7:0], counter cnt[2:0], carry register c_int.
- REPOSO with inicio=1 (accepted inicio):
  - reg_d <= valor_in, cnt <= cant_mov, c_int <= 0.
  - Next state is FIN if cant_mov==0, else DESPLAZANDO.
- REPOSO with inicio=0: hold; valor_desplazado and acarreo keep the previous result.
- DESPLAZANDO, each cycle:
  - reg_d <= {reg_d[6:0],1'b0}, c_int <= reg_d[7], cnt <= cnt-1.
  - When cnt==1, this is the final shift; next state is FIN.
- FIN:
  - listo=1 for exactly this cycle.
  - valor_desplazado <= reg_d and acarreo <= c_int are loaded on the edge entering FIN, so both are valid while listo=1.
  - Next state is REPOSO unconditionally.
- Logical shift: zeros fill bit 0. Result = (valor_in << N) mod 256. acarreo = valor_in[8-N] for N≥1, and 0 for N=0.
- inicio is ignored while ocupado=1, including the FIN cycle. It is neither queued nor errored.
- valor_in and cant_mov may change freely after acceptance without affecting the operation in flight.

## Timing
- If inicio is accepted in cycle t with shift amount N:
  - ocupado is high in cycles t+1 .. t+N+1.
  - listo is high in cycle t+N+1 only.
  - The earliest next accepted inicio is cycle t+N+2.
- Latency from accept to listo is N+1 cycles: 1 cycle for N=0, 8 cycles for N=7.
- Throughput is one operation per N+2 cycles.
- listo and ocupado are decoded from the registered state. valor_desplazado and acarreo are registered and glitch-free.
- Reset values (rst_n=0 at a rising edge): state=REPOSO, valor_desplazado=8'h00, acarreo=0, ocupado=0, listo=0, reg_d=0, cnt=0, c_int=0.
- Reset takes priority over all other inputs.
- Reset mid-operation aborts the operation: no listo pulse is produced and the partial result is discarded.
- inicio held high continuously restarts an operation on each REPOSO cycle, i.e. every N+2 cycles.

## Test plan
- valor_in=8'hB5, cant_mov=3, inicio pulse at t -> ocupado high t+1..t+4; listo only at t+4; valor_desplazado=8'hA8; acarreo=1.
- valor_in=8'h3C, cant_mov=0 -> listo at t+1; valor_desplazado=8'h3C; acarreo=0; ocupado high for exactly 1 cycle.
- valor_in=8'h83, cant_mov=7 -> listo at t+8; valor_desplazado=8'h80; acarreo=1.
- Start 8'hFF shift 4, then pulse inicio with 8'h01 shift 1 at t+2 and again at t+5 (the FIN cycle) -> both ignored; result 8'hF0, acarreo=1; a new inicio at t+6 is accepted.
- Start 8'h55 shift 5, assert rst_n=0 at t+3 -> all outputs 0 the next cycle; no listo pulse; a subsequent 8'h55 shift 1 gives 8'hAA, acarreo=0.
- Result hold: after the 8'hB5/3 completion, keep inicio=0 for 10 cycles -> valor_desplazado stays 8'hA8, acarreo stays 1, listo stays 0.
